// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its byte-stream loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Instruction presented to IF while loading or after a bad fetch.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Word that ends a program download.
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage array: one write port, one synchronous read port.
// Latency: read data registered one edge after re; write lands on the edge.
// Backpressure: none; rdata holds its value while re is low.
// Ports: clk; we/waddr/wdata write port; re/raddr/rdata read port.
module imem_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Array deliberately has no reset so a reset keeps the loaded program.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader and a byte-addressed fetch port.
// Latency: fetch 1 cycle (pc at edge N -> o_instr after N); word written on the edge taking its 4th byte.
// Backpressure: none; loader accepts a byte whenever i_byte_valid in LOAD, i_fetch_en low holds fetch outputs.
// Ports: i_clk/i_rst; loader i_load_start, i_byte_valid, i_byte -> o_loading, o_load_done, o_full, o_word_count;
//        fetch i_fetch_en, i_pc -> o_instr, o_addr_err.
module imem_loader
  import imem_pkg::*;
#(
  parameter int                    MEM_DEPTH   = 64,
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    BYTE_WIDTH  = 8,
  parameter int                    ADDR_LENGTH = 32,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD   = WORD_WIDTH'(DEFAULT_HALT_WORD)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_load_start,
  input  logic                           i_byte_valid,
  input  logic [BYTE_WIDTH-1:0]          i_byte,
  output logic                           o_loading,
  output logic                           o_load_done,
  output logic                           o_full,
  output logic [$clog2(MEM_DEPTH+1)-1:0] o_word_count,
  input  logic                           i_fetch_en,
  input  logic [ADDR_LENGTH-1:0]         i_pc,
  output logic [WORD_WIDTH-1:0]          o_instr,
  output logic                           o_addr_err
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2(MEM_DEPTH + 1);
  localparam int PW = WORD_WIDTH - BYTE_WIDTH;  // first three bytes of a word

  state_t                 state;
  logic [1:0]             byte_cnt;
  logic [PW-1:0]          pack;
  logic [AW-1:0]          wptr;
  logic [CW-1:0]          word_count;
  logic                   full;
  logic                   loading;
  logic                   load_done;
  logic                   nop_sel;
  logic                   addr_err;

  logic [WORD_WIDTH-1:0]  word;
  logic                   byte_take;
  logic                   we;
  logic                   last_slot;
  logic [ADDR_LENGTH-1:0] idx;
  logic                   pc_err;
  logic                   re;
  logic [WORD_WIDTH-1:0]  rdata;

  // The 4th byte completes the word directly from the input, so it is
  // written on the same edge that samples it.
  assign word      = {pack, i_byte};
  // A restart pulse takes priority: a byte arriving with it is dropped.
  assign byte_take = (state == ST_LOAD) && i_byte_valid && !i_load_start;
  assign we        = byte_take && (byte_cnt == 2'd3);
  assign last_slot = (wptr == AW'(MEM_DEPTH - 1));

  assign idx    = i_pc >> 2;
  assign pc_err = (i_pc[1:0] != 2'b00) || (idx >= ADDR_LENGTH'(MEM_DEPTH));
  // Reads are blocked while loading, so a read never meets a write to the same slot.
  assign re     = i_fetch_en && (state != ST_LOAD) && !pc_err;

  imem_ram #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (WORD_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (we),
    .waddr (wptr),
    .wdata (word),
    .re    (re),
    .raddr (idx[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= ST_IDLE;
      loading    <= 1'b0;
      load_done  <= 1'b0;
      byte_cnt   <= 2'd0;
      pack       <= '0;
      wptr       <= '0;
      word_count <= '0;
      full       <= 1'b0;
    end else if (i_load_start) begin
      // Any state restarts; a partially packed word is simply forgotten.
      state      <= ST_LOAD;
      loading    <= 1'b1;
      load_done  <= 1'b0;
      byte_cnt   <= 2'd0;
      wptr       <= '0;
      word_count <= '0;
      full       <= 1'b0;
    end else if (byte_take) begin
      pack     <= {pack[PW-BYTE_WIDTH-1:0], i_byte};
      byte_cnt <= byte_cnt + 2'd1;
      if (we) begin
        wptr       <= wptr + AW'(1);
        word_count <= word_count + CW'(1);
        if ((word == HALT_WORD) || last_slot) begin
          state     <= ST_DONE;
          loading   <= 1'b0;
          load_done <= 1'b1;
          // HALT in the last slot still counts as a clean termination.
          full      <= (word != HALT_WORD);
        end
      end
    end
  end

  // nop_sel masks the RAM output, so reset/load/error all present NOP
  // while the RAM read register itself stays reset-free.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      nop_sel  <= 1'b1;
      addr_err <= 1'b0;
    end else if (state == ST_LOAD) begin
      nop_sel  <= 1'b1;
      addr_err <= 1'b0;
    end else if (i_fetch_en) begin
      nop_sel  <= pc_err;
      addr_err <= pc_err;
    end
  end

  assign o_loading    = loading;
  assign o_load_done  = load_done;
  assign o_full       = full;
  assign o_word_count = word_count;
  assign o_instr      = nop_sel ? WORD_WIDTH'(NOP_WORD) : rdata;
  assign o_addr_err   = addr_err;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader with a 4-word memory: a queue-based model checked every cycle,
// plus directed literal expectations for load, full, fetch errors, stall hold, restart and reset.
module tb_imem_loader;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic          byte_valid;
  logic [7:0]    bval;
  logic          fetch_en;
  logic [31:0]   pc;
  logic          loading;
  logic          load_done;
  logic          full;
  logic [CW-1:0] word_count;
  logic [31:0]   instr;
  logic          addr_err;

  int total = 0;
  int bad   = 0;

  imem_loader #(
    .MEM_DEPTH   (DEPTH),
    .WORD_WIDTH  (32),
    .BYTE_WIDTH  (8),
    .ADDR_LENGTH (32),
    .HALT_WORD   (HALT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_load_start (load_start),
    .i_byte_valid (byte_valid),
    .i_byte       (bval),
    .o_loading    (loading),
    .o_load_done  (load_done),
    .o_full       (full),
    .o_word_count (word_count),
    .i_fetch_en   (fetch_en),
    .i_pc         (pc),
    .o_instr      (instr),
    .o_addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 loading, 2 done. Bytes gather in a queue until four arrive.
  int          m_mode;
  logic [7:0]  q[$];
  int          m_count;
  bit          m_full;
  logic [31:0] m_instr;
  bit          m_iknown;
  bit          m_err;
  logic [31:0] m_mem[DEPTH];
  bit          m_known[DEPTH];

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] w;
    logic [31:0] widx;
    if (!rst_n) begin
      m_mode = 0; q.delete(); m_count = 0; m_full = 0;
      m_instr = 32'h0; m_iknown = 1; m_err = 0;
    end else begin
      // fetch sees the mode as it was before this edge
      widx = pc >> 2;
      if (m_mode == 1) begin
        m_instr = 32'h0; m_iknown = 1; m_err = 0;
      end else if (fetch_en) begin
        if (pc[1:0] != 2'b00 || widx >= 32'(DEPTH)) begin
          m_instr = 32'h0; m_iknown = 1; m_err = 1;
        end else begin
          m_instr = m_mem[widx]; m_iknown = m_known[widx]; m_err = 0;
        end
      end
      if (load_start) begin
        m_mode = 1; q.delete(); m_count = 0; m_full = 0;
      end else if (m_mode == 1 && byte_valid) begin
        q.push_back(bval);
        if (q.size() == 4) begin
          w = {q[0], q[1], q[2], q[3]};
          q.delete();
          m_mem[m_count]   = w;
          m_known[m_count] = 1;
          m_count++;
          if (w == HALT) begin
            m_mode = 2; m_full = 0;
          end else if (m_count == DEPTH) begin
            m_mode = 2; m_full = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_loading",    32'(loading),    32'(m_mode == 1));
      check("m_load_done",  32'(load_done),  32'(m_mode == 2));
      check("m_full",       32'(full),       32'(m_full));
      check("m_word_count", 32'(word_count), 32'(m_count));
      check("m_addr_err",   32'(addr_err),   32'(m_err));
      if (m_iknown) check("m_instr", instr, m_instr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1; bval = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_en = 1'b1; pc = a;
    @(negedge clk);
    fetch_en = 1'b0;
  endtask

  logic [31:0] hold_pcs [3];

  initial begin
    rst_n = 1'b0; load_start = 1'b0; byte_valid = 1'b0; bval = 8'h0;
    fetch_en = 1'b0; pc = 32'h0;
    hold_pcs[0] = 32'h2; hold_pcs[1] = 32'h10; hold_pcs[2] = 32'h8;
    repeat (2) @(negedge clk);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_done",    32'(load_done), 32'd0);
    check("rst_count",   32'(word_count), 32'd0);
    check("rst_instr",   instr, 32'h0);
    check("rst_err",     32'(addr_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic two-word program ending in HALT
    start_load();
    check("load_loading", 32'(loading), 32'd1);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_word(32'hFFFF_FFFF);
    check("basic_count", 32'(word_count), 32'd2);
    check("basic_done",  32'(load_done), 32'd1);
    check("basic_full",  32'(full), 32'd0);
    fetch(32'h0);
    check("fetch0", instr, 32'h2008_0005);
    fetch(32'h4);
    check("fetch4", instr, 32'hFFFF_FFFF);

    // address errors
    fetch(32'h2);
    check("misalign_instr", instr, 32'h0);
    check("misalign_err",   32'(addr_err), 32'd1);
    fetch(32'(4 * DEPTH));
    check("range_instr", instr, 32'h0);
    check("range_err",   32'(addr_err), 32'd1);
    fetch(32'h0);
    check("recover_err",   32'(addr_err), 32'd0);
    check("recover_instr", instr, 32'h2008_0005);

    // stall hold
    fetch(32'h4);
    for (int i = 0; i < 3; i++) begin
      pc = hold_pcs[i];
      @(negedge clk);
      check("hold_instr", instr, 32'hFFFF_FFFF);
      check("hold_err",   32'(addr_err), 32'd0);
    end

    // fill without HALT
    start_load();
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    check("full_flag",  32'(full), 32'd1);
    check("full_count", 32'(word_count), 32'd4);
    check("full_done",  32'(load_done), 32'd1);
    send_word(32'hAABB_CCDD);
    check("full_count_after", 32'(word_count), 32'd4);
    fetch(32'h0);  check("full_w0", instr, 32'h0102_0304);
    fetch(32'h4);  check("full_w1", instr, 32'h0506_0708);
    fetch(32'h8);  check("full_w2", instr, 32'h090A_0B0C);
    fetch(32'hC);  check("full_w3", instr, 32'h0D0E_0F10);

    // restart mid-word, with the byte beside the start pulse dropped; IF keeps fetching
    fetch_en = 1'b1; pc = 32'h0;
    start_load();
    fetch_en = 1'b1;
    send_byte(8'h11); send_byte(8'h22);
    load_start = 1'b1; byte_valid = 1'b1; bval = 8'h33;
    @(negedge clk);
    load_start = 1'b0; byte_valid = 1'b0;
    check("restart_nop", instr, 32'h0);
    check("restart_count", 32'(word_count), 32'd0);
    send_word(32'h4455_6677);
    send_word(32'hFFFF_FFFF);
    check("restart_count2", 32'(word_count), 32'd2);
    @(negedge clk);
    check("restart_w0", instr, 32'h4455_6677);
    fetch_en = 1'b0;

    // asynchronous reset partway through a load
    start_load();
    send_word(32'h1234_5678);
    send_byte(8'h9A);
    #2 rst_n = 1'b0;
    #1;
    check("arst_loading", 32'(loading), 32'd0);
    check("arst_count",   32'(word_count), 32'd0);
    check("arst_done",    32'(load_done), 32'd0);
    check("arst_instr",   instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(32'h0BAD_0BAD);
    check("post_rst_count",   32'(word_count), 32'd0);
    check("post_rst_loading", 32'(loading), 32'd0);
    fetch(32'h0);
    check("post_rst_w0", instr, 32'h1234_5678);

    // a fresh load is accepted again after reset
    start_load();
    send_word(32'hA1B2_C3D4);
    send_word(32'hFFFF_FFFF);
    check("reload_count", 32'(word_count), 32'd2);
    fetch(32'h0);
    check("reload_w0", instr, 32'hA1B2_C3D4);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
